// File: rtl/se_arb_pkg.sv
// se_arb_pkg: shared types and defaults for the SE arbiter (FSM states, owner, counter width).
// Pure declarations: no latency, no backpressure.
package se_arb_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int INST_W_DEF = 8;
    localparam int CNT_W      = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_RESP
    } state_t;

    typedef logic owner_t;

endpackage

// File: rtl/se_arbiter_if.sv
// se_arbiter_if: bundle of the two requester ports, the SE port and status; master = arbiter side.
// Wires only: no latency; valid/ready handshakes on every channel.
interface se_arbiter_if
    import se_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int INST_W = INST_W_DEF
);
    logic [INST_W-1:0] r0_in_inst,  r1_in_inst;
    logic [DATA_W-1:0] r0_in_op1,   r1_in_op1;
    logic [DATA_W-1:0] r0_in_op2,   r1_in_op2;
    logic [DATA_W-1:0] r0_in_cond,  r1_in_cond;
    logic              r0_in_valid, r1_in_valid;
    logic              r0_in_ready, r1_in_ready;
    logic [DATA_W-1:0] r0_out_result, r1_out_result;
    logic              r0_out_valid,  r1_out_valid;
    logic              r0_out_ready,  r1_out_ready;

    logic [INST_W-1:0] se_in_inst;
    logic [DATA_W-1:0] se_in_op1, se_in_op2, se_in_cond;
    logic              se_in_valid, se_in_ready;
    logic [DATA_W-1:0] se_out_result;
    logic              se_out_valid, se_out_ready;

    logic              busy;
    owner_t            owner;
    logic              overrun;

    modport master (
        input  r0_in_inst, r0_in_op1, r0_in_op2, r0_in_cond, r0_in_valid, r0_out_ready,
        input  r1_in_inst, r1_in_op1, r1_in_op2, r1_in_cond, r1_in_valid, r1_out_ready,
        output r0_in_ready, r0_out_result, r0_out_valid,
        output r1_in_ready, r1_out_result, r1_out_valid,
        output se_in_inst, se_in_op1, se_in_op2, se_in_cond, se_in_valid, se_out_ready,
        input  se_in_ready, se_out_result, se_out_valid,
        output busy, owner, overrun
    );

    modport slave (
        output r0_in_inst, r0_in_op1, r0_in_op2, r0_in_cond, r0_in_valid, r0_out_ready,
        output r1_in_inst, r1_in_op1, r1_in_op2, r1_in_cond, r1_in_valid, r1_out_ready,
        input  r0_in_ready, r0_out_result, r0_out_valid,
        input  r1_in_ready, r1_out_result, r1_out_valid,
        input  se_in_inst, se_in_op1, se_in_op2, se_in_cond, se_in_valid, se_out_ready,
        output se_in_ready, se_out_result, se_out_valid,
        input  busy, owner, overrun
    );

endinterface

// File: rtl/se_arb_rr.sv
// se_arb_rr: 2-way round-robin picker; a lone request wins, a tie goes to the pointer.
// Combinational, no backpressure.
module se_arb_rr
    import se_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  owner_t     ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant[ptr] = 1'b1;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/se_arbiter.sv
// se_arbiter: shares one SE between two requesters, one transaction at a time; SE_ARB_CONST_TIME_EN pads responses to PAD_CYCLES+1 after SE accept and flags overrun.
// Latency: grant -> SE issue next cycle, response SE latency+1 (padded: max(lat,PAD_CYCLES)+1); backpressure: requests stall while busy, RESP holds until out_ready.
module se_arbiter
    import se_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int INST_W     = INST_W_DEF,
    parameter int PAD_CYCLES = 32
) (
    input logic          clock,
    input logic          reset,
    se_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(PAD_CYCLES - 1);

    state_t            state;
    owner_t            owner_q;
    owner_t            ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [INST_W-1:0] inst_q;
    logic [DATA_W-1:0] op1_q, op2_q, cond_q, result_q;
    logic [1:0]        req_vld;
    logic [1:0]        grant;
    logic              idle;
    logic              resp_rdy;
`ifdef SE_ARB_CONST_TIME_EN
    logic              overrun_q;
`endif

    assign idle     = (state == ST_IDLE);
    assign req_vld  = {bus.r1_in_valid, bus.r0_in_valid};
    assign cnt_nxt  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign resp_rdy = owner_q ? bus.r1_out_ready : bus.r0_out_ready;

    se_arb_rr u_rr (
        .valid (req_vld),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            inst_q   <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            cond_q   <= '0;
            result_q <= '0;
`ifdef SE_ARB_CONST_TIME_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        owner_q <= grant[1];
                        ptr_q   <= ~grant[1];
                        inst_q  <= grant[1] ? bus.r1_in_inst : bus.r0_in_inst;
                        op1_q   <= grant[1] ? bus.r1_in_op1  : bus.r0_in_op1;
                        op2_q   <= grant[1] ? bus.r1_in_op2  : bus.r0_in_op2;
                        cond_q  <= grant[1] ? bus.r1_in_cond : bus.r0_in_cond;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.se_in_ready) begin
                        cnt_q <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_nxt;
                    if (bus.se_out_valid) begin
                        result_q <= bus.se_out_result;
`ifdef SE_ARB_CONST_TIME_EN
                        // A result at count PAD-1 already meets the padded deadline; HOLD would overshoot it.
                        if (cnt_q > PAD_LAST) begin
                            overrun_q <= 1'b1;
                            state     <= ST_RESP;
                        end else if (cnt_q == PAD_LAST) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_HOLD;
                        end
`else
                        state <= ST_RESP;
`endif
                    end
                end
                ST_HOLD: begin
                    cnt_q <= cnt_nxt;
                    if (cnt_q == PAD_LAST) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_rdy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.r0_in_ready   = idle & grant[0];
    assign bus.r1_in_ready   = idle & grant[1];
    assign bus.se_in_inst    = inst_q;
    assign bus.se_in_op1     = op1_q;
    assign bus.se_in_op2     = op2_q;
    assign bus.se_in_cond    = cond_q;
    assign bus.se_in_valid   = (state == ST_ISSUE);
    assign bus.se_out_ready  = (state == ST_WAIT);
    assign bus.r0_out_valid  = (state == ST_RESP) & ~owner_q;
    assign bus.r1_out_valid  = (state == ST_RESP) & owner_q;
    assign bus.r0_out_result = result_q;
    assign bus.r1_out_result = result_q;
    assign bus.busy          = ~idle;
    assign bus.owner         = owner_q;
`ifdef SE_ARB_CONST_TIME_EN
    assign bus.overrun       = overrun_q;
`else
    assign bus.overrun       = 1'b0;
`endif

endmodule

// File: tb/tb_se_arbiter.sv
// tb_se_arbiter: random requesters and SE against a timestamp-based transaction model, plus directed arbitration/latency/reset cases.
module tb_se_arbiter;

    localparam int DW  = 128;
    localparam int IW  = 8;
    localparam int PAD = 32;
`ifdef SE_ARB_CONST_TIME_EN
    localparam bit CONST_T = 1'b1;
`else
    localparam bit CONST_T = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    se_arbiter_if #(.DATA_W(DW), .INST_W(IW)) bus ();

    se_arbiter #(.DATA_W(DW), .INST_W(IW), .PAD_CYCLES(PAD)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // stimulus knobs
    bit rst_knob  = 1'b1;
    bit rand_req  = 1'b0;
    bit want [2]  = '{1'b0, 1'b0};
    int req_pct   = 30;
    int ordy_pct  = 100;
    int irdy_pct  = 100;
    int force_lat = 0;

    // requester and SE stand-ins
    bit            rq_pend [2] = '{1'b0, 1'b0};
    logic [IW-1:0] rq_inst [2];
    logic [DW-1:0] rq_op1 [2], rq_op2 [2], rq_cond [2];
    bit            se_pend = 1'b0;
    int            se_cnt  = 0;
    logic [DW-1:0] se_res;

    // transaction model: one in flight, timestamps of its milestones
    bit            m_active  = 1'b0;
    bit            m_owner   = 1'b0;
    bit            m_ptr     = 1'b0;
    bit            m_overrun = 1'b0;
    int            t_acc = -1, t_seo = -1, t_resp = 0;
    logic [IW-1:0] m_inst;
    logic [DW-1:0] m_op1, m_op2, m_cond;
    logic [DW-1:0] m_result = '0;

    // observations for directed literal checks
    int glog[$];
    int obs_acc  = -1;
    int obs_resp = -1;
    int n_outv   = 0;

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] d = '0;
        for (int i = 0; i < DW; i += 32) d = (d << 32) | DW'($urandom);
        return d;
    endfunction

    function automatic logic [DW-1:0] se_fn(input logic [IW-1:0] i, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] c);
        return (a + b) ^ c ^ DW'(i);
    endfunction

    function automatic int gl(input int i);
        return (glog.size() > i) ? glog[i] : -1;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic [1:0] eg;
        logic [1:0] ev_out;
        int n;
        int lat;
        int l_obs;
        @(negedge clk);
        reset = rst_knob;
        for (int i = 0; i < 2; i++) begin
            if (!rq_pend[i] && (want[i] || (rand_req && $urandom_range(99) < req_pct))) begin
                rq_pend[i] = 1'b1;
                rq_inst[i] = IW'($urandom);
                rq_op1[i]  = rnd();
                rq_op2[i]  = rnd();
                rq_cond[i] = rnd();
            end
        end
        bus.r0_in_valid  = rq_pend[0];
        bus.r0_in_inst   = rq_inst[0];
        bus.r0_in_op1    = rq_op1[0];
        bus.r0_in_op2    = rq_op2[0];
        bus.r0_in_cond   = rq_cond[0];
        bus.r1_in_valid  = rq_pend[1];
        bus.r1_in_inst   = rq_inst[1];
        bus.r1_in_op1    = rq_op1[1];
        bus.r1_in_op2    = rq_op2[1];
        bus.r1_in_cond   = rq_cond[1];
        bus.r0_out_ready = ($urandom_range(99) < ordy_pct);
        bus.r1_out_ready = ($urandom_range(99) < ordy_pct);
        bus.se_in_ready  = ($urandom_range(99) < irdy_pct);
        bus.se_out_valid = 1'b0;
        bus.se_out_result = rnd();
        if (se_pend) begin
            se_cnt--;
            if (se_cnt == 0) begin
                se_pend = 1'b0;
                bus.se_out_valid  = 1'b1;
                bus.se_out_result = se_res;
            end
        end
        #1;

        eg = 2'b00;
        if (!m_active) begin
            if (rq_pend[0] && rq_pend[1]) eg[m_ptr] = 1'b1;
            else eg = {rq_pend[1], rq_pend[0]};
        end
        ev_out = 2'b00;
        if (m_active && t_seo >= 0 && cyc >= t_resp) ev_out[m_owner] = 1'b1;

        if (!reset) begin
            chk("r0_in_ready", bus.r0_in_ready, eg[0]);
            chk("r1_in_ready", bus.r1_in_ready, eg[1]);
            chk("se_in_valid", bus.se_in_valid, m_active && t_acc < 0);
            chk("se_out_ready", bus.se_out_ready, m_active && t_acc >= 0 && t_seo < 0);
            chk("r0_out_valid", bus.r0_out_valid, ev_out[0]);
            chk("r1_out_valid", bus.r1_out_valid, ev_out[1]);
            chk("busy", bus.busy, m_active);
            chk("owner", bus.owner, m_owner);
            chk("overrun", bus.overrun, m_overrun);
            if (m_active && t_acc < 0) begin
                chk("se_in_inst", bus.se_in_inst, m_inst);
                chk("se_in_op1", bus.se_in_op1, m_op1);
                chk("se_in_op2", bus.se_in_op2, m_op2);
                chk("se_in_cond", bus.se_in_cond, m_cond);
            end
            if (ev_out[0]) chk("r0_out_result", bus.r0_out_result, m_result);
            if (ev_out[1]) chk("r1_out_result", bus.r1_out_result, m_result);

            if (bus.r0_in_ready) glog.push_back(0);
            if (bus.r1_in_ready) glog.push_back(1);
            if (bus.se_in_valid && bus.se_in_ready) begin
                obs_acc  = cyc;
                obs_resp = -1;
            end
            if ((bus.r0_out_valid || bus.r1_out_valid) && obs_acc >= 0 && obs_resp < 0) obs_resp = cyc;
            if (bus.r0_out_valid || bus.r1_out_valid) n_outv++;
        end

        if (reset) begin
            m_active  = 1'b0;
            m_ptr     = 1'b0;
            m_owner   = 1'b0;
            m_overrun = 1'b0;
            m_result  = '0;
        end else if (!m_active) begin
            if (eg != 2'b00) begin
                n        = eg[1] ? 1 : 0;
                m_active = 1'b1;
                m_owner  = eg[1];
                m_ptr    = !eg[1];
                m_inst   = rq_inst[n];
                m_op1    = rq_op1[n];
                m_op2    = rq_op2[n];
                m_cond   = rq_cond[n];
                t_acc    = -1;
                t_seo    = -1;
                rq_pend[n] = 1'b0;
            end
        end else if (t_acc < 0) begin
            if (bus.se_in_ready) begin
                t_acc   = cyc;
                lat     = (force_lat > 0) ? force_lat : int'($urandom_range(CONST_T ? 45 : 12, 1));
                se_pend = 1'b1;
                se_cnt  = lat;
                se_res  = se_fn(m_inst, m_op1, m_op2, m_cond);
            end
        end else if (t_seo < 0) begin
            if (bus.se_out_valid) begin
                t_seo    = cyc;
                m_result = bus.se_out_result;
                l_obs    = cyc - t_acc;
                if (CONST_T) begin
                    t_resp = t_acc + ((l_obs > PAD) ? l_obs : PAD) + 1;
                    if (l_obs > PAD) m_overrun = 1'b1;
                end else begin
                    t_resp = cyc + 1;
                end
            end
        end else if (cyc >= t_resp) begin
            if (m_owner ? bus.r1_out_ready : bus.r0_out_ready) m_active = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset(input bit keep_se);
        rst_knob = 1'b1;
        rand_req = 1'b0;
        want[0] = 1'b0;
        want[1] = 1'b0;
        rq_pend[0] = 1'b0;
        rq_pend[1] = 1'b0;
        if (!keep_se) se_pend = 1'b0;
        repeat (3) step();
        rst_knob = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        step();
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_owner"}, bus.owner, 1'b0);
        chk({tag, "_overrun"}, bus.overrun, 1'b0);
        chk({tag, "_r0_out_valid"}, bus.r0_out_valid, 1'b0);
        chk({tag, "_r1_out_valid"}, bus.r1_out_valid, 1'b0);
        chk({tag, "_se_in_valid"}, bus.se_in_valid, 1'b0);
        chk({tag, "_se_out_ready"}, bus.se_out_ready, 1'b0);
        chk({tag, "_r0_out_result"}, bus.r0_out_result, '0);
        chk({tag, "_se_in_op1"}, bus.se_in_op1, '0);
        chk({tag, "_se_in_inst"}, bus.se_in_inst, '0);
    endtask

    task automatic run_lat(input int lat, input int exp_d, input string nm);
        int g0;
        force_lat = lat;
        ordy_pct  = 100;
        obs_acc   = -1;
        obs_resp  = -1;
        g0 = glog.size();
        want[0] = 1'b1;
        for (int i = 0; i < 20 && glog.size() == g0; i++) step();
        want[0] = 1'b0;
        for (int i = 0; i < 400 && obs_resp < 0; i++) step();
        chk_i(nm, obs_resp - obs_acc, exp_d);
        repeat (3) step();
    endtask

    initial begin
        do_reset(1'b0);
        reset_checks("rst0");

        // both request in the first idle cycle: r0 then r1
        do_reset(1'b0);
        glog.delete();
        force_lat = 3; ordy_pct = 100; irdy_pct = 100;
        want[0] = 1'b1; want[1] = 1'b1;
        for (int i = 0; i < 200 && glog.size() < 2; i++) step();
        want[0] = 1'b0; want[1] = 1'b0;
        chk_i("rr_both_first", gl(0), 0);
        chk_i("rr_both_second", gl(1), 1);

        // r1 alone, then both: r1 then r0
        do_reset(1'b0);
        glog.delete();
        want[1] = 1'b1;
        for (int i = 0; i < 50 && glog.size() < 1; i++) step();
        want[0] = 1'b1;
        for (int i = 0; i < 200 && glog.size() < 2; i++) step();
        want[0] = 1'b0; want[1] = 1'b0;
        chk_i("rr_r1_first", gl(0), 1);
        chk_i("rr_then_r0", gl(1), 0);

        // response latency, padded or not, and sticky overrun
        do_reset(1'b0);
        irdy_pct = 60;
        run_lat(5, CONST_T ? 33 : 6, "lat5_delta");
        run_lat(20, CONST_T ? 33 : 21, "lat20_delta");
        run_lat(32, 33, "lat32_delta");
        chk("overrun_after_lat32", bus.overrun, 1'b0);
        run_lat(40, 41, "lat40_delta");
        chk("overrun_after_lat40", bus.overrun, CONST_T);
        run_lat(5, CONST_T ? 33 : 6, "lat5_again_delta");
        chk("overrun_sticky", bus.overrun, CONST_T);

        // owner withholds out_ready for 10 cycles while both keep requesting
        do_reset(1'b0);
        glog.delete();
        ordy_pct = 0; force_lat = 2; irdy_pct = 100;
        want[0] = 1'b1; want[1] = 1'b1;
        for (int i = 0; i < 200 && !(m_active && t_seo >= 0 && cyc >= t_resp); i++) step();
        repeat (10) step();
        chk("hold_busy", bus.busy, 1'b1);
        chk("hold_r0_out_valid", bus.r0_out_valid, 1'b1);
        chk_i("hold_no_new_grant", glog.size(), 1);
        want[0] = 1'b0; want[1] = 1'b0;
        ordy_pct = 100;
        repeat (10) step();

        // reset while waiting on the SE; its late result must be ignored
        do_reset(1'b0);
        force_lat = 30; irdy_pct = 100; ordy_pct = 100;
        want[0] = 1'b1;
        for (int i = 0; i < 50 && !(m_active && t_acc >= 0); i++) step();
        want[0] = 1'b0;
        repeat (5) step();
        chk("pre_reset_in_wait", bus.se_out_ready, 1'b1);
        do_reset(1'b1);
        n_outv = 0;
        repeat (40) step();
        chk_i("rst_wait_no_resp", n_outv, 0);
        chk("rst_wait_idle", bus.busy, 1'b0);
        chk_i("rst_wait_se_fired", int'(se_pend), 0);

        // random traffic
        do_reset(1'b0);
        force_lat = 0; rand_req = 1'b1;
        req_pct = 30; ordy_pct = 60; irdy_pct = 60;
        repeat (4000) step();
        do_reset(1'b0);
        reset_checks("rst_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/se_arbiter.md
SE_ARBITER -- requirements
Module: se_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 128, operand/result width.
REQ-002 SHALL have parameter INST_W, default 8, instruction width.
REQ-003 SHALL have parameter PAD_CYCLES, default 32, constant-time response latency in cycles; range 2..255.
REQ-004 SHALL have one clock, `clock`; reset is synchronous and active-high, named `reset`.
REQ-005 Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  sync active-high reset
- `rN_in_inst`  in  INST_W  requester N instruction (N=0,1)
- `rN_in_op1` / `rN_in_op2` / `rN_in_cond`  in  DATA_W each  requester N operands
- `rN_in_valid`  in  1  requester N request
- `rN_in_ready`  out  1  request accepted
- `rN_out_result`  out  DATA_W  response data
- `rN_out_valid`  out  1  response valid
- `rN_out_ready`  in  1  requester N accepts response
- `se_in_inst` / `se_in_op1` / `se_in_op2` / `se_in_cond`  out  INST_W/DATA_W  to SE
- `se_in_valid`  out  1  to SE
- `se_in_ready`  in  1  from SE
- `se_out_result`  in  DATA_W  from SE
- `se_out_valid`  in  1  from SE
- `se_out_ready`  out  1  to SE
- `busy`  out  1  transaction in flight
- `owner`  out  1  granted requester
- `overrun`  out  1  sticky; SE exceeded PAD_CYCLES

Function
REQ-006 SHALL implement FSM IDLE, ISSUE, WAIT, HOLD, RESP, with one transaction in flight at a time.
REQ-007 IDLE: if exactly one `rN_in_valid` is high, that requester SHALL be granted; if both are high, the one selected by the round-robin pointer SHALL be granted.
REQ-008 Grant cycle: `rN_in_ready`=1 for the granted requester only (combinational, IDLE-qualified); request fields latched; `owner`=N; pointer set to the other requester; next state ISSUE.
REQ-009 ISSUE: `se_in_valid`=1 with latched fields; on `se_in_ready`, latency counter cleared to 0 and next state WAIT.
REQ-010 Latency counter SHALL increment each cycle in WAIT/HOLD and saturate at 255.
REQ-011 WAIT: `se_out_ready`=1; on `se_out_valid`, result latched; next state HOLD with CONST_TIME, RESP without it.
REQ-012 HOLD: next state RESP when counter == PAD_CYCLES-1, giving exactly PAD_CYCLES+1 cycles from SE accept to `rN_out_valid` regardless of SE latency.
REQ-013 If `se_out_valid` arrives with counter >= PAD_CYCLES (CONST_TIME only), `overrun` SHALL set and the FSM SHALL go directly to RESP.
REQ-014 RESP: owner's `rN_out_valid`=1 and `rN_out_result` stable; other port's `out_valid`=0; on `rN_out_ready`, next state IDLE.
REQ-015 A new grant SHALL NOT occur in the same cycle as the RESP handshake; minimum 1 IDLE cycle between transactions.
REQ-016 `busy`=1 in all states except IDLE.
REQ-017 `se_in_valid` SHALL be 0 outside ISSUE; `se_out_ready` SHALL be 0 outside WAIT.

Reset
REQ-018 Reset SHALL set state IDLE, pointer 0, `owner` 0, `overrun` 0, counter 0, all valid/ready outputs 0, and all result/data outputs 0.
REQ-019 Reset mid-transaction SHALL abandon it with no response issued; a late `se_out_valid` after reset is ignored because `se_out_ready`=0 in IDLE.

Configuration
REQ-020 Macro SE_ARB_CONST_TIME_EN defined: HOLD state and `overrun` active per REQ-012/013.
REQ-021 Macro undefined: HOLD is unreachable, response follows SE latency, and `overrun` is tied to 0.

Structure
REQ-022 Package se_arb_pkg SHALL hold the FSM state enum, the owner type, and DATA_W/INST_W defaults.
REQ-023 Sub-module se_arb_rr SHALL implement the 2-way round-robin picker (valids, pointer -> grant).

Verification
REQ-024 Both requests in the first IDLE cycle after reset -> r0 granted, then r1 on the next transaction.
REQ-025 Only r1 valid, then both valid -> r1, then r0.
REQ-026 CONST_TIME, PAD_CYCLES=32, SE latency 5 -> `rN_out_valid` exactly 33 cycles after the SE accept; latency 20 -> same 33.
REQ-027 CONST_TIME, SE latency 40 -> `overrun`=1 and response 1 cycle after `se_out_valid`; flag stays set until reset.
REQ-028 `rN_out_ready` held low 10 cycles -> result stable, no new grant, `busy`=1.
REQ-029 Reset asserted in WAIT, then SE returns `se_out_valid` -> no `rN_out_valid` and state IDLE.
